serial_out_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing one serial output buffer between NUM_REQ requesters.

---
 rtl/serial_out_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_serial_out_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_out_arbiter.sv
// ---------------------------------------------------------------------------
// serial_out_arbiter
//
// Round-robin arbiter and sequencer that shares one serial output buffer
// between NUM_REQ requesters. A winning request's 7-bit address and 8-bit
// data are captured into sob_a/sob_d, the buffer's Go input is pulsed, and
// the block then waits out the whole serial frame plus an inter-frame gap
// before it is willing to grant the next requester.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   FRAME_BITS  bits shifted per frame by the serial output buffer
//   GAP_CYCLES  idle cycles inserted after each frame (0 allowed)
//
// Ports
//   clk_in      in   1           single clock, rising edge
//   reset_n     in   1           synchronous reset, ACTIVE-HIGH despite name
//   req         in   NUM_REQ     level request per requester, held until ack
//   req_addr    in   NUM_REQ*7   address of requester i at [7*i+6:7*i]
//   req_data    in   NUM_REQ*8   data of requester i at [8*i+7:8*i]
//   ack         out  NUM_REQ     one-cycle one-hot pulse: request i captured
//   busy        out  1           high whenever the sequencer is not idle
//   frame_done  out  1           one-cycle pulse at the end of the frame
//   sob_go      out  1           one-cycle Go pulse to the serial buffer
//   sob_a       out  7           address to the buffer, held until next grant
//   sob_d       out  8           data to the buffer, held until next grant
// ---------------------------------------------------------------------------
module serial_out_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FRAME_BITS = 19,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 sob_go,
  output logic [6:0]           sob_a,
  output logic [7:0]           sob_d
);

  // The counter has to hold the larger of the two reload values.
  localparam int CNT_MAX = (FRAME_BITS > GAP_CYCLES) ? FRAME_BITS : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [NUM_REQ-1:0] ack_next;
  logic               frame_done_next;
  logic               sob_go_next;
  logic [6:0]         sob_a_next;
  logic [7:0]         sob_d_next;

  logic               grant_valid;
  int                 grant_int;
  int                 scan_idx;

  // Round-robin pick. The scan runs from the farthest offset back towards
  // rr_ptr so that the closest set request (lowest offset) overwrites any
  // earlier hit and ends up as the winner without needing a found flag.
  always_comb begin
    grant_valid = 1'b0;
    grant_int   = 0;
    scan_idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_int   = scan_idx;
      end
    end
  end

  // Next-state and next-output logic. All outputs except busy are
  // registered, so each pulse appears in the cycle after the edge that
  // takes the corresponding decision: ack after the grant, sob_go after
  // LOAD, frame_done after the last SHIFT cycle.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    rr_ptr_next     = rr_ptr;
    ack_next        = '0;
    frame_done_next = 1'b0;
    sob_go_next     = 1'b0;
    sob_a_next      = sob_a;
    sob_d_next      = sob_d;

    case (state)
      IDLE: begin
        if (grant_valid) begin
          sob_a_next          = req_addr[7*grant_int +: 7];
          sob_d_next          = req_data[8*grant_int +: 8];
          ack_next[grant_int] = 1'b1;
          rr_ptr_next         = PTR_W'((grant_int + 1) % NUM_REQ);
          state_next          = LOAD;
        end
      end

      LOAD: begin
        sob_go_next = 1'b1;
        cnt_next    = CNT_W'(FRAME_BITS);
        state_next  = SHIFT;
      end

      SHIFT: begin
        // The <= guard keeps the counter from ever wrapping below 1.
        if (cnt <= CNT_W'(1)) begin
          frame_done_next = 1'b1;
          if (GAP_CYCLES == 0) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next   = CNT_W'(GAP_CYCLES);
            state_next = GAP;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset overrides everything, including a
  // frame in progress; the buffer is reset alongside, so an aborted frame
  // is simply dropped.
  always_ff @(posedge clk_in) begin
    if (reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      ack        <= '0;
      frame_done <= 1'b0;
      sob_go     <= 1'b0;
      sob_a      <= '0;
      sob_d      <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      rr_ptr     <= rr_ptr_next;
      ack        <= ack_next;
      frame_done <= frame_done_next;
      sob_go     <= sob_go_next;
      sob_a      <= sob_a_next;
      sob_d      <= sob_d_next;
    end
  end

  // busy follows the state register directly so it drops in the same
  // cycle the sequencer returns to IDLE.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_out_arbiter
//
// Drives two copies of serial_out_arbiter from the same stimulus: one with
// the default inter-frame gap and one with no gap. A timeline model predicts
// every output of both copies from the grant edge of the current frame;
// directed scenarios add hand-computed expectations on top.
// ---------------------------------------------------------------------------
module tb_serial_out_arbiter;

  localparam int N     = 4;
  localparam int FB    = 19;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;

  logic         clk_in   = 1'b0;
  logic         reset_n  = 1'b1;
  logic [N-1:0] req      = '0;
  logic [N*7-1:0] req_addr = '0;
  logic [N*8-1:0] req_data = '0;

  logic [N-1:0] ack_a, ack_b;
  logic         busy_a, busy_b;
  logic         frame_done_a, frame_done_b;
  logic         sob_go_a, sob_go_b;
  logic [6:0]   sob_a_a, sob_a_b;
  logic [7:0]   sob_d_a, sob_d_b;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;
  int edge_n     = 0;

  // Model state per DUT copy: edge of the current grant, pointer, winner
  // and captured address/data.
  int         gap_cfg    [2] = '{GAP_A, GAP_B};
  int         grant_edge [2] = '{-1000, -1000};
  int         m_ptr      [2] = '{0, 0};
  int         m_win      [2] = '{0, 0};
  logic [6:0] m_a        [2] = '{7'h0, 7'h0};
  logic [7:0] m_d        [2] = '{8'h0, 8'h0};

  int ack_log_a [$];
  int go_log_a  [$];
  int go_log_b  [$];

  int         d_m;
  logic [N-1:0] e_ack;

  always #5 clk_in = ~clk_in;

  serial_out_arbiter #(.NUM_REQ(N), .FRAME_BITS(FB), .GAP_CYCLES(GAP_A)) dut_a (
    .clk_in(clk_in), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .ack(ack_a), .busy(busy_a), .frame_done(frame_done_a),
    .sob_go(sob_go_a), .sob_a(sob_a_a), .sob_d(sob_d_a)
  );

  serial_out_arbiter #(.NUM_REQ(N), .FRAME_BITS(FB), .GAP_CYCLES(GAP_B)) dut_b (
    .clk_in(clk_in), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .ack(ack_b), .busy(busy_b), .frame_done(frame_done_b),
    .sob_go(sob_go_b), .sob_a(sob_a_b), .sob_d(sob_d_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] r);
    reset_n = rst;
    req     = r;
  endtask

  task automatic setSlot(input int i, input logic [6:0] a, input logic [7:0] d);
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = d;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while ((busy_a || busy_b) && n < budget);
    checkOutput("idle_reached", {31'd0, !(busy_a || busy_b)}, 32'd1);
  endtask

  // First set request at or after ptr, going round the requesters in order.
  function automatic int firstFrom(input logic [N-1:0] r, input int ptr);
    for (int j = 0; j < N; j++) begin
      if (r[(ptr + j) % N]) return (ptr + j) % N;
    end
    return 0;
  endfunction

  function automatic int oneHotIndex(input logic [N-1:0] v);
    for (int j = 0; j < N; j++) begin
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Timeline model: a copy is free to grant once 2+FB+gap edges have
  // passed since its last grant; everything else is a fixed offset from
  // the grant edge.
  always @(posedge clk_in) begin
    edge_n++;
    for (int u = 0; u < 2; u++) begin
      if (reset_n) begin
        grant_edge[u] = -1000;
        m_ptr[u]      = 0;
        m_a[u]        = '0;
        m_d[u]        = '0;
      end else if (edge_n >= grant_edge[u] + 2 + FB + gap_cfg[u] && req != '0) begin
        m_win[u]      = firstFrom(req, m_ptr[u]);
        grant_edge[u] = edge_n;
        m_a[u]        = req_addr[7*m_win[u] +: 7];
        m_d[u]        = req_data[8*m_win[u] +: 8];
        m_ptr[u]      = (m_win[u] + 1) % N;
      end
    end
  end

  // Compare both copies against the model on every cycle.
  always @(negedge clk_in) begin
    if (check_en) begin
      for (int u = 0; u < 2; u++) begin
        d_m   = edge_n - grant_edge[u];
        e_ack = '0;
        if (d_m == 0) e_ack[m_win[u]] = 1'b1;
        checkOutput($sformatf("ack[%0d]", u), (u == 0) ? ack_a : ack_b, e_ack);
        checkOutput($sformatf("sob_go[%0d]", u), (u == 0) ? sob_go_a : sob_go_b, (d_m == 1));
        checkOutput($sformatf("frame_done[%0d]", u), (u == 0) ? frame_done_a : frame_done_b,
                    (d_m == FB + 1));
        checkOutput($sformatf("busy[%0d]", u), (u == 0) ? busy_a : busy_b,
                    (d_m >= 0 && d_m <= FB + gap_cfg[u]));
        checkOutput($sformatf("sob_a[%0d]", u), (u == 0) ? sob_a_a : sob_a_b, m_a[u]);
        checkOutput($sformatf("sob_d[%0d]", u), (u == 0) ? sob_d_a : sob_d_b, m_d[u]);
      end
      if (ack_a != '0) ack_log_a.push_back(oneHotIndex(ack_a));
      if (sob_go_a) go_log_a.push_back(edge_n);
      if (sob_go_b) go_log_b.push_back(edge_n);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int fd;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    // T1: reset held for three edges with every requester asking.
    applyStimulus(1'b1, 4'b1111);
    @(negedge clk_in);
    check_en = 1'b1;
    repeat (2) @(negedge clk_in);
    checkOutput("t1_ack", ack_a, 32'h0);
    checkOutput("t1_busy", busy_a, 32'h0);
    checkOutput("t1_go", sob_go_a, 32'h0);
    checkOutput("t1_done", frame_done_a, 32'h0);
    checkOutput("t1_sob_a", sob_a_a, 32'h0);
    checkOutput("t1_sob_d", sob_d_a, 32'h0);
    applyStimulus(1'b0, 4'b1111);
    @(negedge clk_in);
    checkOutput("t1_first_ack", ack_a, 32'h1);
    applyStimulus(1'b0, 4'b0000);
    waitIdle(60);

    // T2: single request from requester 2.
    setSlot(2, 7'h55, 8'hA3);
    applyStimulus(1'b0, 4'b0100);
    @(negedge clk_in);
    checkOutput("t2_ack", ack_a, 32'h4);
    applyStimulus(1'b0, 4'b0000);
    @(negedge clk_in);
    checkOutput("t2_go", sob_go_a, 32'h1);
    checkOutput("t2_sob_a", sob_a_a, 32'h55);
    checkOutput("t2_sob_d", sob_d_a, 32'hA3);
    n = 0;
    while (!frame_done_a && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("t2_done_delay", n, 32'd19);
    waitIdle(60);

    // T3: all requesters held after a fresh reset.
    applyStimulus(1'b1, 4'b0000);
    @(negedge clk_in);
    ack_log_a.delete();
    go_log_a.delete();
    go_log_b.delete();
    applyStimulus(1'b0, 4'b1111);
    n = 0;
    while (ack_log_a.size() < 5 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    repeat (2) @(negedge clk_in);
    checkOutput("t3_ack_count", {31'd0, ack_log_a.size() >= 5}, 32'd1);
    checkOutput("t3_go_count_a", {31'd0, go_log_a.size() >= 5}, 32'd1);
    checkOutput("t3_go_count_b", {31'd0, go_log_b.size() >= 5}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t3_order%0d", i),
                  (ack_log_a.size() > i) ? ack_log_a[i] : -1, exp_order[i]);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3_spacing_a%0d", i),
                  (go_log_a.size() > i + 1) ? go_log_a[i+1] - go_log_a[i] : -1, 32'd23);
      checkOutput($sformatf("t3_spacing_b%0d", i),
                  (go_log_b.size() > i + 1) ? go_log_b[i+1] - go_log_b[i] : -1, 32'd21);
    end
    applyStimulus(1'b0, 4'b0000);
    waitIdle(60);

    // T4: grant 1, then 0 and 1 together must wrap the pointer to 0 first.
    applyStimulus(1'b1, 4'b0000);
    @(negedge clk_in);
    applyStimulus(1'b0, 4'b0010);
    @(negedge clk_in);
    checkOutput("t4_first", ack_a, 32'h2);
    applyStimulus(1'b0, 4'b0000);
    waitIdle(60);
    ack_log_a.delete();
    applyStimulus(1'b0, 4'b0011);
    n = 0;
    while (ack_log_a.size() < 2 && n < 80) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("t4_wrap", (ack_log_a.size() > 0) ? ack_log_a[0] : -1, 32'd0);
    checkOutput("t4_next", (ack_log_a.size() > 1) ? ack_log_a[1] : -1, 32'd1);
    applyStimulus(1'b0, 4'b0000);
    waitIdle(60);

    // T5: inputs changing mid-frame must not reach sob_a/sob_d or ack.
    setSlot(3, 7'h11, 8'h22);
    applyStimulus(1'b0, 4'b1000);
    @(negedge clk_in);
    checkOutput("t5_ack", ack_a, 32'h8);
    applyStimulus(1'b0, 4'b0000);
    repeat (3) @(negedge clk_in);
    setSlot(3, 7'h7F, 8'hFF);
    applyStimulus(1'b0, 4'b0111);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      checkOutput("t5_sob_a_hold", sob_a_a, 32'h11);
      checkOutput("t5_sob_d_hold", sob_d_a, 32'h22);
      checkOutput("t5_no_ack", ack_a, 32'h0);
    end
    n = 0;
    while (ack_a == '0 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("t5_next_ack", ack_a, 32'h1);
    applyStimulus(1'b0, 4'b0000);
    waitIdle(60);

    // T6: reset while the frame counter is at 10.
    setSlot(2, 7'h2A, 8'h5C);
    applyStimulus(1'b0, 4'b0100);
    n = 0;
    while (!sob_go_a && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("t6_go_seen", sob_go_a, 32'h1);
    applyStimulus(1'b0, 4'b0000);
    repeat (9) @(negedge clk_in);
    applyStimulus(1'b1, 4'b0000);
    @(negedge clk_in);
    checkOutput("t6_busy", busy_a, 32'h0);
    checkOutput("t6_sob_a", sob_a_a, 32'h0);
    applyStimulus(1'b0, 4'b0000);
    fd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (frame_done_a) fd++;
    end
    checkOutput("t6_no_frame_done", fd, 32'd0);
    applyStimulus(1'b0, 4'b1111);
    @(negedge clk_in);
    checkOutput("t6_ptr_reset", ack_a, 32'h1);
    applyStimulus(1'b0, 4'b0000);
    waitIdle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
